hazard_tracker: RTL and testbench

Parametrised hazard and forwarding controller for the in-order MIPS pipeline; successor to the fixed 5-stage load-use detector and two-source forwarding unit. Tracks every in-flight register writer in a STAGES-deep tag shift register. Each cycle it decides whether the instruction in ID must stall, and registers per-source forwarding selects for that instruction's EX cycle. It supports any source count and any load latency, and adds flush handling and a stall counter.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/hazard_tracker_if.sv | 33 +++
 rtl/hazard_src_match.sv | 44 ++++
 rtl/hazard_tracker.sv | 79 +++++++
 tb/tb_hazard_tracker.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the hazard tracker, the pipeline registers
// and the EX forwarding mux.
//   PIPE_AW       : register address width carried in a tag entry
//   *_DEF         : default tracked-stage count and forwarding readiness
//   REG_ZERO      : hard-wired zero register, never a real producer
//   FWD_RF        : forwarding select meaning "use the register-file value"
//   tag_t         : one in-flight writer {v, dst, wr, ld}
package pipe_pkg;

    localparam int PIPE_AW      = 5;
    localparam int STAGES_DEF   = 3;
    localparam int ALU_RDY_DEF  = 1;
    localparam int LOAD_RDY_DEF = 2;
    localparam int FWD_RF       = 0;

    localparam logic [PIPE_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic               v;
        logic [PIPE_AW-1:0] dst;
        logic               wr;
        logic               ld;
    } tag_t;

endpackage

// File: rtl/hazard_tracker_if.sv
// ID-stage hazard/forwarding bus between the pipeline and hazard_tracker.
//   master : pipeline side, drives the ID instruction fields and flush
//   slave  : tracker side, returns stall, ex_fwd_sel and stall_cnt
interface hazard_tracker_if
    import pipe_pkg::*;
#(
    parameter int REG_AW  = PIPE_AW,
    parameter int NUM_SRC = 2,
    parameter int SEL_W   = $clog2(STAGES_DEF + 1)
);

    logic                      id_valid;
    logic [NUM_SRC*REG_AW-1:0] id_src;
    logic [NUM_SRC-1:0]        id_src_used;
    logic [REG_AW-1:0]         id_dst;
    logic                      id_wr;
    logic                      id_load;
    logic                      flush;
    logic                      stall;
    logic [NUM_SRC*SEL_W-1:0]  ex_fwd_sel;
    logic [31:0]               stall_cnt;

    modport master (
        output id_valid, id_src, id_src_used, id_dst, id_wr, id_load, flush,
        input  stall, ex_fwd_sel, stall_cnt
    );

    modport slave (
        input  id_valid, id_src, id_src_used, id_dst, id_wr, id_load, flush,
        output stall, ex_fwd_sel, stall_cnt
    );

endinterface

// File: rtl/hazard_src_match.sv
// Per-source producer search for one ID source operand.
//   src, srcUsed : source register number and whether it is actually read
//   tags         : all in-flight writers, index 0 = EX
//   hazard       : the youngest producer will not be forwardable in time
//   sel          : forwarding select for this source's EX cycle
module hazard_src_match
    import pipe_pkg::*;
#(
    parameter int REG_AW   = PIPE_AW,
    parameter int STAGES   = STAGES_DEF,
    parameter int ALU_RDY  = ALU_RDY_DEF,
    parameter int LOAD_RDY = LOAD_RDY_DEF,
    parameter int SEL_W    = $clog2(STAGES + 1)
) (
    input  logic [REG_AW-1:0]     src,
    input  logic                  srcUsed,
    input  tag_t [STAGES-1:0]     tags,
    output logic                  hazard,
    output logic [SEL_W-1:0]      sel
);

    always_comb begin
        hazard = 1'b0;
        sel    = SEL_W'(FWD_RF);
        // Walk oldest to youngest so the youngest matching writer decides last.
        for (int s = STAGES - 1; s >= 0; s--) begin
            if (srcUsed && tags[s].v && tags[s].wr &&
                tags[s].dst != REG_ZERO && tags[s].dst == src) begin
                // s+1 is where the producer sits once the consumer reaches EX.
                if (s + 1 >= STAGES) begin
                    hazard = 1'b0;
                    sel    = SEL_W'(FWD_RF);
                end else if (s + 1 >= (tags[s].ld ? LOAD_RDY : ALU_RDY)) begin
                    hazard = 1'b0;
                    sel    = SEL_W'(s + 1);
                end else begin
                    hazard = 1'b1;
                    sel    = SEL_W'(FWD_RF);
                end
            end
        end
    end

endmodule

// File: rtl/hazard_tracker.sv
// Hazard and forwarding controller for the in-order pipeline.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : ID instruction in; stall (combinational), ex_fwd_sel (registered,
//           aligned with the instruction in EX) and saturating stall_cnt out
module hazard_tracker
    import pipe_pkg::*;
#(
    parameter int REG_AW   = PIPE_AW,
    parameter int NUM_SRC  = 2,
    parameter int STAGES   = STAGES_DEF,
    parameter int ALU_RDY  = ALU_RDY_DEF,
    parameter int LOAD_RDY = LOAD_RDY_DEF,
    parameter int SEL_W    = $clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    hazard_tracker_if.slave  bus
);

    tag_t [STAGES-1:0]        tagQ;
    tag_t                     idEntry;
    logic [NUM_SRC-1:0]       hazardVec;
    logic [NUM_SRC*SEL_W-1:0] selNext;
    logic [NUM_SRC*SEL_W-1:0] fwdSelQ;
    logic [31:0]              stallCntQ;
    logic                     stallInt;
    logic                     issue;

    for (genvar g = 0; g < NUM_SRC; g++) begin : gen_src
        hazard_src_match #(
            .REG_AW   (REG_AW),
            .STAGES   (STAGES),
            .ALU_RDY  (ALU_RDY),
            .LOAD_RDY (LOAD_RDY),
            .SEL_W    (SEL_W)
        ) u_match (
            .src     (bus.id_src[g*REG_AW +: REG_AW]),
            .srcUsed (bus.id_src_used[g]),
            .tags    (tagQ),
            .hazard  (hazardVec[g]),
            .sel     (selNext[g*SEL_W +: SEL_W])
        );
    end

    // Flush wins over a hazard: the squashed instruction never waits.
    assign stallInt = bus.id_valid & ~bus.flush & (|hazardVec);
    assign issue    = bus.id_valid & ~stallInt & ~bus.flush;

    always_comb begin
        idEntry     = '0;
        idEntry.v   = issue;
        idEntry.dst = bus.id_dst;
        idEntry.wr  = bus.id_wr;
        idEntry.ld  = bus.id_load;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tagQ      <= '0;
            fwdSelQ   <= '0;
            stallCntQ <= '0;
        end else begin
            tagQ[0] <= idEntry;
            for (int s = 1; s < STAGES; s++) begin
                tagQ[s] <= tagQ[s-1];
            end
            fwdSelQ <= issue ? selNext : '0;
            if (stallInt && stallCntQ != 32'hFFFF_FFFF) begin
                stallCntQ <= stallCntQ + 32'd1;
            end
        end
    end

    assign bus.stall      = stallInt;
    assign bus.ex_fwd_sel = fwdSelQ;
    assign bus.stall_cnt  = stallCntQ;

endmodule

// File: tb/tb_hazard_tracker.sv
module tb_hazard_tracker;

    typedef struct {
        bit         valid;
        logic [4:0] s0;
        logic [4:0] s1;
        logic [1:0] used;
        logic [4:0] dst;
        bit         wr;
        bit         ld;
        bit         flush;
        bit         expStall;
        logic [1:0] f0;
        logic [1:0] f1;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       idValid;
    logic [9:0] idSrc;
    logic [1:0] idUsed;
    logic [4:0] idDst;
    logic       idWr;
    logic       idLoad;
    logic       idFlush;

    int checks = 0;
    int errors = 0;
    int expCntA = 0;

    logic [3:0] expQA[$];
    logic [5:0] expQB[$];
    vec_t       tbl[$];

    always #5 clk = ~clk;

    hazard_tracker_if                                       ifA ();
    hazard_tracker_if #(.REG_AW(5), .NUM_SRC(2), .SEL_W(3)) ifB ();

    assign ifA.id_valid = idValid;      assign ifB.id_valid = idValid;
    assign ifA.id_src = idSrc;          assign ifB.id_src = idSrc;
    assign ifA.id_src_used = idUsed;    assign ifB.id_src_used = idUsed;
    assign ifA.id_dst = idDst;          assign ifB.id_dst = idDst;
    assign ifA.id_wr = idWr;            assign ifB.id_wr = idWr;
    assign ifA.id_load = idLoad;        assign ifB.id_load = idLoad;
    assign ifA.flush = idFlush;         assign ifB.flush = idFlush;

    hazard_tracker dutA (.clk(clk), .reset(reset), .bus(ifA));

    hazard_tracker #(.STAGES(4), .LOAD_RDY(3)) dutB (.clk(clk), .reset(reset), .bus(ifB));

    function automatic vec_t mkVec(bit valid, int s0, int s1, int used, int dst,
                                   bit wr, bit ld, bit flush, bit st, int f0, int f1);
        vec_t r;
        r.valid = valid;     r.s0 = 5'(s0);   r.s1 = 5'(s1);
        r.used = 2'(used);   r.dst = 5'(dst); r.wr = wr;
        r.ld = ld;           r.flush = flush; r.expStall = st;
        r.f0 = 2'(f0);       r.f1 = 2'(f1);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        idValid = v.valid;
        idSrc   = {v.s1, v.s0};
        idUsed  = v.used;
        idDst   = v.dst;
        idWr    = v.wr;
        idLoad  = v.ld;
        idFlush = v.flush;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycleAB(input vec_t v, input string name, input bit chkB,
                           input bit bStall, input int b0, input int b1);
        logic [3:0] ea;
        logic [5:0] eb;
        drive(v);
        #4;
        chk({name, " stallA"}, 32'(ifA.stall), 32'(v.expStall));
        expQA.push_back((v.valid && !v.flush && !v.expStall) ? {v.f1, v.f0} : 4'd0);
        if (chkB) begin
            chk({name, " stallB"}, 32'(ifB.stall), 32'(bStall));
            expQB.push_back((v.valid && !v.flush && !bStall) ? {3'(b1), 3'(b0)} : 6'd0);
        end
        @(posedge clk);
        #1;
        ea = expQA.pop_front();
        chk({name, " fwdA"}, 32'(ifA.ex_fwd_sel), 32'(ea));
        if (chkB) begin
            eb = expQB.pop_front();
            chk({name, " fwdB"}, 32'(ifB.ex_fwd_sel), 32'(eb));
        end
        @(negedge clk);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t nop;
        vec_t lw8;
        vec_t use88;
        nop   = mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        lw8   = mkVec(1, 0, 0, 0, 8, 1, 1, 0, 0, 0, 0);
        use88 = mkVec(1, 8, 8, 3, 9, 1, 0, 0, 0, 0, 0);

        // load-use: one stall, then forward from stage 2 on both sources
        tbl.push_back(lw8);
        tbl.push_back(mkVec(1, 8, 8, 3, 9, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mkVec(1, 8, 8, 3, 9, 1, 0, 0, 0, 2, 2));
        tbl.push_back(nop); tbl.push_back(nop); tbl.push_back(nop);
        // ALU back-to-back: src0 from EX/MEM, src1 register file
        tbl.push_back(mkVec(1, 1, 2, 3, 8, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mkVec(1, 8, 10, 3, 9, 1, 0, 0, 0, 1, 0));
        tbl.push_back(nop); tbl.push_back(nop);
        // two nops between: producer retired
        tbl.push_back(mkVec(1, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0));
        tbl.push_back(nop); tbl.push_back(nop);
        tbl.push_back(mkVec(1, 8, 0, 1, 9, 1, 0, 0, 0, 0, 0));
        // one nop between: forward from stage 2
        tbl.push_back(mkVec(1, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0));
        tbl.push_back(nop);
        tbl.push_back(mkVec(1, 8, 0, 1, 9, 1, 0, 0, 0, 2, 0));
        // two writers of r8 in flight: youngest wins
        tbl.push_back(mkVec(1, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mkVec(1, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mkVec(1, 8, 0, 1, 9, 1, 0, 0, 0, 1, 0));
        // load writing r0, then a load reading r0: never a match
        tbl.push_back(mkVec(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mkVec(1, 0, 0, 1, 5, 1, 1, 0, 0, 0, 0));
        // flush on a load-use hazard: no stall, no issue
        tbl.push_back(lw8);
        tbl.push_back(mkVec(1, 8, 8, 3, 9, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mkVec(1, 9, 0, 1, 12, 1, 0, 0, 0, 0, 0));
        // invalid ID never stalls
        tbl.push_back(lw8);
        tbl.push_back(mkVec(0, 8, 8, 3, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(nop);

        reset = 1'b0;
        drive(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #3;
        chk("reset stallA", 32'(ifA.stall), 32'd0);
        chk("reset fwdA", 32'(ifA.ex_fwd_sel), 32'd0);
        chk("reset cntA", ifA.stall_cnt, 32'd0);
        chk("reset cntB", ifB.stall_cnt, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        foreach (tbl[i]) begin
            cycleAB(tbl[i], $sformatf("row%0d", i), 1'b0, 1'b0, 0, 0);
            expCntA += int'(tbl[i].expStall);
        end
        chk("table cntA", ifA.stall_cnt, 32'(expCntA));

        // reset asserted during an active load-use stall
        cycleAB(lw8, "rst_lw", 1'b0, 1'b0, 0, 0);
        drive(use88);
        #2;
        chk("rst_pre stallA", 32'(ifA.stall), 32'd1);
        chk("rst_pre stallB", 32'(ifB.stall), 32'd1);
        reset = 1'b0;
        #1;
        chk("rst stallA", 32'(ifA.stall), 32'd0);
        chk("rst fwdA", 32'(ifA.ex_fwd_sel), 32'd0);
        chk("rst cntA", ifA.stall_cnt, 32'd0);
        chk("rst stallB", 32'(ifB.stall), 32'd0);
        chk("rst fwdB", 32'(ifB.ex_fwd_sel), 32'd0);
        chk("rst cntB", ifB.stall_cnt, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // tracker empty after reset: the dependent instruction issues at once
        cycleAB(use88, "post0", 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) cycleAB(nop, $sformatf("drain%0d", i), 1'b1, 1'b0, 0, 0);

        // load-use on both builds: defaults stall 1, deep build stalls 2 then sel 3
        cycleAB(lw8, "lu_lw", 1'b1, 1'b0, 0, 0);
        cycleAB(mkVec(1, 8, 8, 3, 9, 1, 0, 0, 1, 0, 0), "lu1", 1'b1, 1'b1, 0, 0);
        cycleAB(mkVec(1, 8, 8, 3, 9, 1, 0, 0, 0, 2, 2), "lu2", 1'b1, 1'b1, 0, 0);
        cycleAB(mkVec(1, 8, 8, 3, 9, 1, 0, 0, 0, 0, 0), "lu3", 1'b1, 1'b0, 3, 3);
        cycleAB(nop, "lu4", 1'b1, 1'b0, 0, 0);
        chk("final cntA", ifA.stall_cnt, 32'd1);
        chk("final cntB", ifB.stall_cnt, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
